// File: rtl/rv32_ctrl_pkg.sv
// Shared types and constants for the RV32 multi-cycle controller.
package rv32_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } ctrl_state_e;

  typedef enum logic [2:0] {
    ClsNone,
    ClsR,
    ClsI,
    ClsLoad,
    ClsStore
  } instr_cls_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  function automatic instr_cls_e classify(input logic [6:0] op);
    instr_cls_e cls;
    case (op)
      OP_R:     cls = ClsR;
      OP_I:     cls = ClsI;
      OP_LOAD:  cls = ClsLoad;
      OP_STORE: cls = ClsStore;
      default:  cls = ClsNone;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/rv32_alu_dec.sv
// Combinational ALU decode: instruction class + funct3/funct7 to ALU control,
// operand-B select and illegal-instruction flag.
module rv32_alu_dec
  import rv32_ctrl_pkg::*;
(
  input  instr_cls_e cls_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [2:0] alu_control_o,
  output logic       alu_src_o,
  output logic       illegal_o
);

  logic [2:0] f3_op;
  logic       unused_funct7;

  // Only funct7[5] matters, and only for R-type add/sub.
  assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};

  always_comb begin
    f3_op = ALU_ADD;
    unique case (funct3_i)
      3'b000:  f3_op = (cls_i == ClsR && funct7_i[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_ADD;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      3'b111:  f3_op = ALU_AND;
      default: f3_op = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_control_o = ALU_ADD;
    alu_src_o     = 1'b1;
    illegal_o     = 1'b0;
    case (cls_i)
      ClsR: begin
        alu_control_o = f3_op;
        alu_src_o     = 1'b0;
        illegal_o     = (funct3_i == 3'b011);
      end
      ClsI: begin
        alu_control_o = f3_op;
        illegal_o     = (funct3_i == 3'b011);
      end
      ClsLoad, ClsStore: begin
        alu_control_o = ALU_ADD;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32 sequencer sharing one memory port between fetch and load/store.
// Optional performance counters enabled by defining RV32_CTRL_PERF_CNT_EN.
module rv32_multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
`ifdef RV32_CTRL_PERF_CNT_EN
  ,
  parameter int unsigned PERF_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       alu_src,
  output logic [2:0] alu_control,
  output logic       result_src,
  output logic       halted,
  output logic       err_illegal,
  output logic       err_timeout
`ifdef RV32_CTRL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instret_cnt
`endif
);

  localparam logic [7:0] WaitMax8 = 8'(WAIT_MAX);

  ctrl_state_e state_q;
  instr_cls_e  cls_q;
  instr_cls_e  dec_cls;
  logic [7:0]  wait_cnt_q;
  logic [2:0]  alu_control_q;
  logic        alu_src_q;
  logic        result_src_q;
  logic        err_illegal_q;
  logic        err_timeout_q;
  logic [2:0]  dec_alu_control;
  logic        dec_alu_src;
  logic        dec_illegal;
  logic        timeout_hit;

  assign dec_cls     = classify(opcode);
  assign timeout_hit = (wait_cnt_q == WaitMax8);

  rv32_alu_dec u_alu_dec (
    .cls_i        (dec_cls),
    .funct3_i     (funct3),
    .funct7_i     (funct7),
    .alu_control_o(dec_alu_control),
    .alu_src_o    (dec_alu_src),
    .illegal_o    (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StFetch;
      cls_q         <= ClsNone;
      wait_cnt_q    <= '0;
      alu_control_q <= ALU_ADD;
      alu_src_q     <= 1'b0;
      result_src_q  <= 1'b0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (mem_ready) begin
            state_q    <= StDecode;
            wait_cnt_q <= '0;
          end else if (timeout_hit) begin
            state_q       <= StHalt;
            err_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StDecode: begin
          cls_q         <= dec_cls;
          alu_control_q <= dec_alu_control;
          alu_src_q     <= dec_alu_src;
          result_src_q  <= (dec_cls == ClsLoad);
          wait_cnt_q    <= '0;
          if (dec_illegal) begin
            state_q       <= StHalt;
            err_illegal_q <= 1'b1;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          wait_cnt_q <= '0;
          state_q    <= (cls_q == ClsLoad || cls_q == ClsStore) ? StMem : StWb;
        end
        StMem: begin
          if (mem_ready) begin
            state_q    <= (cls_q == ClsStore) ? StFetch : StWb;
            wait_cnt_q <= '0;
          end else if (timeout_hit) begin
            state_q       <= StHalt;
            err_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StWb: begin
          state_q    <= StFetch;
          wait_cnt_q <= '0;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: state_q <= StHalt;
      endcase
    end
  end

  // Strobes are gated by rst_n so a request in flight drops the moment reset asserts.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    halted    = 1'b0;
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        StMem: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (cls_q == ClsStore);
        end
        StWb:    reg_write = 1'b1;
        StHalt:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign alu_control = alu_control_q;
  assign alu_src     = alu_src_q;
  assign result_src  = result_src_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;

`ifdef RV32_CTRL_PERF_CNT_EN
  logic [PERF_W-1:0] cycle_cnt_q;
  logic [PERF_W-1:0] instret_cnt_q;
  logic              retire;

  assign retire = (state_q == StWb) ||
                  (state_q == StMem && mem_ready && cls_q == ClsStore);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else if (state_q != StHalt) begin
      cycle_cnt_q <= cycle_cnt_q + PERF_W'(1);
      if (retire) begin
        instret_cnt_q <= instret_cnt_q + PERF_W'(1);
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed self-checking bench for rv32_multicycle_ctrl (WAIT_MAX = 4).
module tb_rv32_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       alu_src;
  logic [2:0] alu_control;
  logic       result_src;
  logic       halted;
  logic       err_illegal;
  logic       err_timeout;
`ifdef RV32_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  int errors;
  int checks;
  int cyc_n;

  rv32_multicycle_ctrl #(
    .WAIT_MAX(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src    (alu_src),
    .alu_control(alu_control),
    .result_src (result_src),
    .halted     (halted),
    .err_illegal(err_illegal),
    .err_timeout(err_timeout)
`ifdef RV32_CTRL_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_ir(input logic [31:0] w);
    opcode = w[6:0];
    funct3 = w[14:12];
    funct7 = w[31:25];
  endtask

  // Advance to the middle of the next cycle with mem_ready driven for that cycle.
  task automatic go(input logic rdy);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    cyc_n++;
    #1;
  endtask

  task automatic release_rst(input logic rdy);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mem_ready = rdy;
    cyc_n     = 1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int seen;
    errors    = 0;
    checks    = 0;
    cyc_n     = 0;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    load_ir(32'h002081B3);
    #12;

    // Reset state
    check("rst_mem_req", mem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_flags", {err_illegal, err_timeout, ir_write, reg_write}, 4'b0000);
    check("rst_alu", {alu_control, alu_src, result_src}, 5'b0);

    // add, zero-wait fetch
    release_rst(1'b1);
    check("add_c1_fetch", {mem_req, addr_sel, mem_we, ir_write, pc_write}, 5'b10011);
    go(1'b0);
    check("add_c2_decode_req", mem_req, 0);
    check("add_c2_ir_write", ir_write, 0);
    go(1'b0);
    check("add_c3_alu", {alu_control, alu_src}, {3'b000, 1'b0});
    check("add_c3_reg_write", reg_write, 0);
    go(1'b0);
    check("add_c4_wb", {reg_write, result_src}, 2'b10);
    load_ir(32'h402081B3);
    go(1'b1);
    check("add_c5_fetch", {mem_req, reg_write, ir_write}, 3'b101);

    // sub then addi
    go(1'b0);
    go(1'b0);
    check("sub_exec_alu", {alu_control, alu_src}, {3'b001, 1'b0});
    go(1'b0);
    check("sub_wb", reg_write, 1);
    load_ir(32'h40008093);
    go(1'b1);
    go(1'b0);
    go(1'b0);
    check("addi_exec_alu", {alu_control, alu_src}, {3'b000, 1'b1});
    go(1'b0);
    check("addi_wb", {reg_write, result_src}, 2'b10);

    // lw with data-phase ready delayed by 3 cycles
    load_ir(32'h0000A183);
    go(1'b1);
    start = cyc_n;
    go(1'b0);
    go(1'b0);
    check("lw_exec_alu", {alu_control, alu_src}, {3'b000, 1'b1});
    for (int i = 0; i < 4; i++) begin
      go(i == 3);
      check($sformatf("lw_mem%0d", i), {mem_req, addr_sel, mem_we}, 3'b110);
    end
    go(1'b0);
    check("lw_wb", {reg_write, result_src}, 2'b11);
    load_ir(32'h0030A023);
    go(1'b1);
    check("lw_next_fetch", {mem_req, addr_sel}, 2'b10);
    check("lw_latency", cyc_n - start, 8);

    // sw with one wait cycle in MEM
    start = cyc_n;
    seen  = 0;
    go(1'b0);
    seen += reg_write;
    go(1'b0);
    seen += reg_write;
    for (int i = 0; i < 2; i++) begin
      go(i == 1);
      seen += reg_write;
      check($sformatf("sw_mem%0d", i), {mem_req, addr_sel, mem_we}, 3'b111);
    end
    load_ir(32'h00000063);
    go(1'b1);
    check("sw_back_fetch", {mem_req, addr_sel, mem_we}, 3'b100);
    check("sw_no_reg_write", seen, 0);
    check("sw_latency", cyc_n - start, 5);

    // beq: illegal -> HALT
    go(1'b0);
    check("beq_decode", {halted, err_illegal}, 2'b00);
    go(1'b0);
    check("beq_halt", {halted, err_illegal, err_timeout}, 3'b110);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      go(1'b1);
      seen += mem_req;
    end
    check("halt_no_req", seen, 0);
    check("halt_sticky", {halted, err_illegal}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("halt_rst_clear", {halted, err_illegal, err_timeout, mem_req}, 4'b0000);

    // Fetch timeout: ready never comes
    release_rst(1'b0);
    seen = mem_req;
    for (int i = 0; i < 4; i++) begin
      go(1'b0);
      seen += mem_req;
    end
    check("to_req_cycles", seen, 5);
    go(1'b0);
    check("to_halt", {mem_req, err_timeout, halted, err_illegal}, 4'b0110);
    rst_n = 1'b0;
    #1;
    check("to_rst_clear", {err_timeout, halted}, 2'b00);

    // Ready in the WAIT_MAX cycle wins, then reset mid-MEM store
    load_ir(32'h0030A023);
    release_rst(1'b0);
    for (int i = 0; i < 3; i++) go(1'b0);
    go(1'b1);
    check("to_edge_ir_write", ir_write, 1);
    go(1'b0);
    check("to_edge_decode", {mem_req, err_timeout, halted}, 3'b000);
    go(1'b0);
    go(1'b0);
    check("mid_mem_store", {mem_req, mem_we, addr_sel}, 3'b111);
    rst_n = 1'b0;
    #1;
    check("mid_mem_rst", {mem_req, mem_we, reg_write}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_multicycle_ctrl.md
Name: rv32_multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32 datapath. It shares a single memory port between instruction fetch and load/store data access. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives PC, IR, register-file, ALU and memory-handshake controls. It sits between the IR/PC registers and the shared memory, replacing single-cycle decode with a state machine.

Parameters:
- WAIT_MAX, 15: max cycles a memory request may wait for mem_ready before timeout; legal range 1..255.
- PERF_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]; stable from the cycle after the FETCH handshake
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  write enable, qualified by mem_req
- addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result register
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  PC <= PC+4
- reg_write  out  1  register-file write strobe
- alu_src  out  1  0 = rs2, 1 = immediate
- alu_control  out  3  ALU operation
- result_src  out  1  writeback source: 0 = ALU, 1 = memory read data
- halted  out  1  sticky stop indication
- err_illegal  out  1  sticky: unsupported opcode
- err_timeout  out  1  sticky: memory wait exceeded WAIT_MAX

Behaviour:
- Reset (async, rst_n=0): state=FETCH, wait counter=0, all outputs 0. mem_req drops immediately, even mid-access. First request is issued in the first cycle after rst_n deasserts.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are decoded from registered state plus inputs. There are no output latches.
- FETCH:
  - Drive mem_req=1, addr_sel=0, mem_we=0.
  - In the mem_ready cycle: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle. Classify the opcode:
  - 0110011 = R
  - 0010011 = I
  - 0000011 = LOAD
  - 0100011 = STORE
  - Any class goes to EXEC. Any other opcode goes to HALT and sets err_illegal.
- EXEC: one cycle. alu_control and alu_src are valid here and are held through MEM/WB.
  - R/I go to WB.
  - LOAD/STORE go to MEM.
- MEM:
  - Drive mem_req=1, addr_sel=1, mem_we=1 for STORE only.
  - On mem_ready: STORE goes to FETCH, LOAD goes to WB.
- WB: reg_write=1 for exactly one cycle. result_src=1 for LOAD, 0 otherwise. Then go to FETCH.
- HALT: all strobes 0 and halted=1. Exits only via reset.
- ALU encoding:
  - ADD 000, SUB 001, AND 010, OR 011, SLL 100, SLT 101, XOR 110, SRL 111.
  - R-type: funct3 000 with funct7[5]=1 selects SUB, else ADD. 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND. funct3 011 is illegal.
  - I-type: same funct3 map with funct7 ignored (ADDI, not SUB). funct3 011 is illegal.
  - LOAD/STORE: ADD with alu_src=1.
  - R-type: alu_src=0.
- Handshake:
  - While mem_req=1, addr_sel and mem_we are stable until the mem_ready cycle.
  - mem_ready while mem_req=0 is ignored.
  - A mem_ready arriving in the same cycle as the request completes it (zero-wait).
- Latency with zero-wait memory: R/I = 4 cycles, STORE = 4, LOAD = 5 (FETCH to FETCH).
- Timeout:
  - The counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 && !mem_ready.
  - When the counter = WAIT_MAX with no ready: HALT, err_timeout=1, mem_req drops the next cycle.
  - A mem_ready in the WAIT_MAX cycle wins over the timeout.
- Reset asserted mid-MEM store: mem_we drops asynchronously. No partial completion is signalled.

Optional Feature:
- Macro RV32_CTRL_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[PERF_W-1:0] and instret_cnt[PERF_W-1:0].
  - cycle_cnt increments every cycle while not halted.
  - instret_cnt increments on leaving WB and on the STORE MEM-to-FETCH transition.
  - Both wrap modulo 2^PERF_W, reset to 0, and freeze in HALT.
- Undefined: neither port nor counter exists.

Decomposition:
- Package rv32_ctrl_pkg:
  - state enum
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE)
  - ALU op constants (ALU_ADD..ALU_SRL)
  - instruction-class enum
- Sub-module rv32_alu_dec: combinational class + funct3/funct7 to alu_control/alu_src/illegal. It is reused by the FSM and is testable alone.

Test Plan:
- add 0x002081B3, mem_ready same cycle -> ir_write/pc_write in cycle 1; alu_control=000, alu_src=0 in EXEC; single reg_write pulse in cycle 4; mem_req high again in cycle 5.
- sub 0x402081B3 then addi 0x40008093 -> alu_control 001 for sub; 000 with alu_src=1 for addi (funct7[5] ignored).
- lw 0x0000A183, data-phase mem_ready delayed 3 cycles -> mem_req=1, addr_sel=1, mem_we=0 held 4 cycles; WB with result_src=1; 8 cycles FETCH to FETCH.
- sw 0x0030A023 -> MEM with mem_we=1, addr_sel=1; no reg_write ever; returns to FETCH after ready.
- beq 0x00000063 -> HALT after DECODE; err_illegal=1, halted=1; mem_req stays 0 for 20 cycles; rst_n pulse clears all flags.
- WAIT_MAX=4, mem_ready never asserted in FETCH -> err_timeout=1 after 5 request cycles. Repeat with ready in the 5th cycle -> normal DECODE, no error. Assert rst_n=0 mid-MEM -> mem_req=0 in the same cycle.
